// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the MIPS-subset datapath: Moore FSM with
// registered strobes, sized for a one-cycle-latency block memory.
//
// state   | meaning
// --------+----------------------------------------------------------
// FETCH0  | present PC to memory, wait for the synchronous read
// FETCH1  | load IR, PC <= PC + 4
// DECODE  | branch target into ALUOut, dispatch on Op
// MEMADR  | effective address = A + SignImm
// MEMRD   | present ALUOut to memory for a load
// MEMWAIT | Data register captures the memory read data
// MEMWB   | write loaded word into rt
// MEMWR   | single-cycle store at ALUOut
// EXEC    | R-type ALU operation selected by Funct
// ALUWB   | write ALUOut into rd
// BRANCH  | compare A - B, load PC from ALUOut when Zero
// ADDIEX  | A + SignImm
// ADDIWB  | write ALUOut into rt
module mc_control_fsm #(
  parameter logic [5:0] ALU_ADD = 6'd0,
  parameter logic [5:0] ALU_SUB = 6'd1,
  parameter logic [5:0] ALU_AND = 6'd2,
  parameter logic [5:0] ALU_OR  = 6'd3,
  parameter logic [5:0] ALU_SLT = 6'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  output logic        PCWrite,
  output logic        Branch,
  output logic        PCSrc,
  output logic [5:0]  ALUControl,
  output logic [1:0]  ALUSrcB,
  output logic        ALUSrcA,
  output logic        RegWrite,
  output logic        IorD,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic [3:0]  state_o,
  output logic [31:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH0  = 4'd0,
    S_FETCH1  = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWAIT = 4'd5,
    S_MEMWB   = 4'd6,
    S_MEMWR   = 4'd7,
    S_EXEC    = 4'd8,
    S_ALUWB   = 4'd9,
    S_BRANCH  = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] retired_q, retired_d;

  logic       pc_write_q, pc_write_d;
  logic       branch_q, branch_d;
  logic       pc_src_q, pc_src_d;
  logic [5:0] alu_control_q, alu_control_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic       reg_write_q, reg_write_d;
  logic       i_or_d_q, i_or_d_d;
  logic       mem_write_q, mem_write_d;
  logic       ir_write_q, ir_write_d;
  logic       reg_dst_q, reg_dst_d;
  logic       mem_to_reg_q, mem_to_reg_d;

  always_comb begin
    state_d = S_FETCH0;
    case (state_q)
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH0;
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWAIT;
      S_MEMWAIT: state_d = S_MEMWB;
      S_EXEC:    state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH0;
    endcase
  end

  // Strobes are decoded from the next state so the registered outputs line
  // up with state_q; Funct is stable here because IR is not written in DECODE.
  always_comb begin
    pc_write_d    = 1'b0;
    branch_d      = 1'b0;
    pc_src_d      = 1'b0;
    alu_control_d = ALU_ADD;
    alu_src_b_d   = 2'b00;
    alu_src_a_d   = 1'b0;
    reg_write_d   = 1'b0;
    i_or_d_d      = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    reg_dst_d     = 1'b0;
    mem_to_reg_d  = 1'b0;
    case (state_d)
      S_FETCH1: begin
        ir_write_d  = 1'b1;
        alu_src_b_d = 2'b01;
        pc_write_d  = 1'b1;
      end
      S_DECODE: alu_src_b_d = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MEMRD, S_MEMWAIT: i_or_d_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d_d    = 1'b1;
        mem_write_d = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_d = 1'b1;
        case (Funct)
          6'h22:   alu_control_d = ALU_SUB;
          6'h24:   alu_control_d = ALU_AND;
          6'h25:   alu_control_d = ALU_OR;
          6'h2A:   alu_control_d = ALU_SLT;
          default: alu_control_d = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d   = 1'b1;
        alu_control_d = ALU_SUB;
        branch_d      = 1'b1;
        pc_src_d      = 1'b1;
      end
      S_ADDIWB: reg_write_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (state_d == S_FETCH0 && state_q != S_FETCH0)
      retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH0;
      retired_q     <= 32'd0;
      pc_write_q    <= 1'b0;
      branch_q      <= 1'b0;
      pc_src_q      <= 1'b0;
      alu_control_q <= ALU_ADD;
      alu_src_b_q   <= 2'b00;
      alu_src_a_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      i_or_d_q      <= 1'b0;
      mem_write_q   <= 1'b0;
      ir_write_q    <= 1'b0;
      reg_dst_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      retired_q     <= retired_d;
      pc_write_q    <= pc_write_d;
      branch_q      <= branch_d;
      pc_src_q      <= pc_src_d;
      alu_control_q <= alu_control_d;
      alu_src_b_q   <= alu_src_b_d;
      alu_src_a_q   <= alu_src_a_d;
      reg_write_q   <= reg_write_d;
      i_or_d_q      <= i_or_d_d;
      mem_write_q   <= mem_write_d;
      ir_write_q    <= ir_write_d;
      reg_dst_q     <= reg_dst_d;
      mem_to_reg_q  <= mem_to_reg_d;
    end
  end

  assign PCWrite    = pc_write_q;
  assign Branch     = branch_q;
  assign PCSrc      = pc_src_q;
  assign ALUControl = alu_control_q;
  assign ALUSrcB    = alu_src_b_q;
  assign ALUSrcA    = alu_src_a_q;
  assign RegWrite   = reg_write_q;
  assign IorD       = i_or_d_q;
  assign MemWrite   = mem_write_q;
  assign IRWrite    = ir_write_q;
  assign RegDst     = reg_dst_q;
  assign MemtoReg   = mem_to_reg_q;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class state by
// state and compares every strobe against a hand-written per-state table.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Op, Funct;
  logic        PCWrite, Branch, PCSrc, ALUSrcA, RegWrite, IorD;
  logic        MemWrite, IRWrite, RegDst, MemtoReg;
  logic [5:0]  ALUControl;
  logic [1:0]  ALUSrcB;
  logic [3:0]  state_o;
  logic [31:0] retired;

  int total = 0;
  int bad = 0;
  logic [31:0] rexp = 0;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .state_o(state_o), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] ctrl_now();
    return {PCWrite, Branch, PCSrc, ALUControl, ALUSrcB, ALUSrcA,
            RegWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg};
  endfunction

  // Expected strobes per state, written straight from the state list.
  function automatic logic [17:0] exp_ctrl(input int s, input logic [5:0] fn);
    logic pcw, br, pcs, sa, rw, iord, mw, irw, rd, m2r;
    logic [5:0] alu;
    logic [1:0] sb;
    {pcw, br, pcs, sa, rw, iord, mw, irw, rd, m2r} = '0;
    alu = 6'd0;
    sb  = 2'b00;
    case (s)
      1:  begin irw = 1; sb = 2'b01; pcw = 1; end
      2:  sb = 2'b11;
      3:  begin sa = 1; sb = 2'b10; end
      4, 5: iord = 1;
      6:  begin m2r = 1; rw = 1; end
      7:  begin iord = 1; mw = 1; end
      8: begin
        sa = 1;
        case (fn)
          6'h20: alu = 6'd0;
          6'h22: alu = 6'd1;
          6'h24: alu = 6'd2;
          6'h25: alu = 6'd3;
          6'h2A: alu = 6'd4;
          default: alu = 6'd0;
        endcase
      end
      9:  begin rd = 1; rw = 1; end
      10: begin sa = 1; alu = 6'd1; br = 1; pcs = 1; end
      11: begin sa = 1; sb = 2'b10; end
      12: rw = 1;
      default: ;
    endcase
    return {pcw, br, pcs, alu, sb, sa, rw, iord, mw, irw, rd, m2r};
  endfunction

  // Starts at a negedge with state_o == 0; ends at the negedge back in FETCH0.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int len, input int seq [8]);
    Op = op;
    Funct = fn;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s state[%0d]", name, i), {28'd0, state_o}, seq[i]);
      chk($sformatf("%s ctrl[%0d]", name, i), {14'd0, ctrl_now()},
          {14'd0, exp_ctrl(seq[i], fn)});
    end
    rexp = rexp + 1;
    chk($sformatf("%s retired", name), retired, rexp);
  endtask

  initial begin
    rst_n = 1'b0;
    Op = 6'h00;
    Funct = 6'h00;
    #12;
    chk("reset state", {28'd0, state_o}, 32'd0);
    chk("reset retired", retired, 32'd0);
    chk("reset ctrl", {14'd0, ctrl_now()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("lw",   6'h23, 6'h00, 8, '{0, 1, 2, 3, 4, 5, 6, 0});
    run_instr("sw",   6'h2B, 6'h00, 6, '{0, 1, 2, 3, 7, 0, 0, 0});
    run_instr("add",  6'h00, 6'h20, 6, '{0, 1, 2, 8, 9, 0, 0, 0});
    run_instr("sub",  6'h00, 6'h22, 6, '{0, 1, 2, 8, 9, 0, 0, 0});
    run_instr("and",  6'h00, 6'h24, 6, '{0, 1, 2, 8, 9, 0, 0, 0});
    run_instr("or",   6'h00, 6'h25, 6, '{0, 1, 2, 8, 9, 0, 0, 0});
    run_instr("slt",  6'h00, 6'h2A, 6, '{0, 1, 2, 8, 9, 0, 0, 0});
    run_instr("r3f",  6'h00, 6'h3F, 6, '{0, 1, 2, 8, 9, 0, 0, 0});
    run_instr("beq",  6'h04, 6'h2A, 5, '{0, 1, 2, 10, 0, 0, 0, 0});
    run_instr("addi", 6'h08, 6'h22, 6, '{0, 1, 2, 11, 12, 0, 0, 0});
    run_instr("ill",  6'h3F, 6'h22, 4, '{0, 1, 2, 0, 0, 0, 0, 0});

    // Store in flight, then async reset in the middle of MEMWR.
    Op = 6'h2B;
    Funct = 6'h00;
    repeat (4) @(negedge clk);
    chk("swrst state", {28'd0, state_o}, 32'd7);
    chk("swrst memwrite", {31'd0, MemWrite}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst state", {28'd0, state_o}, 32'd0);
    chk("rst memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst ctrl", {14'd0, ctrl_now()}, 32'd0);
    chk("rst retired", retired, 32'd0);
    rexp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("ill2", 6'h3F, 6'h00, 4, '{0, 1, 2, 0, 0, 0, 0, 0});
    run_instr("lw2",  6'h23, 6'h00, 8, '{0, 1, 2, 3, 4, 5, 6, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
